fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 clk  in  1  clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 pc_address  in  32  current virtual fetch PC.
REQ-004 pc_address_psy  in  32  physical address of the current PC.
REQ-005 tlb_miss, tlb_illegal, tlb_invalid, tlb_uncached  in  1 each  translation status of the current PC.
REQ-006 redirect  in  1  branch or exception redirect accepted by the PC this cycle.
REQ-007 fifo_full  in  1  instruction FIFO cannot accept a push this cycle.
REQ-008 pc_en, inst_ok_1, inst_ok_2  out  1 each  PC advance controls.
REQ-009 ireq_valid  out  1; ireq_ready  in  1; ireq_addr  out  32; ireq_uncached  out  1  instruction memory request channel.
REQ-010 irsp_valid  in  1; irsp_data0, irsp_data1  in  32 each  memory response; data1 is the word at ireq_addr+4.
REQ-011 fifo_push0, fifo_push1  out  1 each; fifo_pc  out  32; fifo_inst0, fifo_inst1  out  32 each  FIFO write port.
REQ-012 fetch_exc  out  1; fetch_exc_code  out  2  fetch fault report (0 TLB refill, 1 TLB invalid, 2 address error).

Function
REQ-013 FSM states SHALL be IDLE, REQ, WAIT, DRAIN and FAULT.
REQ-014 IDLE -> REQ the cycle after reset release, and whenever !fifo_full and no fault is pending.
REQ-015 REQ SHALL:
- drive ireq_valid=1, ireq_addr=pc_address_psy, ireq_uncached=tlb_uncached;
- capture pc_address into an internal tag register at the ireq_valid&&ireq_ready handshake;
- move to WAIT on that handshake.
REQ-016 Any of tlb_miss, tlb_invalid or tlb_illegal in IDLE or REQ SHALL suppress ireq_valid and move to FAULT; priority within that check: illegal > miss > invalid.
REQ-017 In FAULT, fetch_exc is held at 1 with the code latched on entry; exit to IDLE only on redirect.
REQ-018 WAIT, irsp_valid=1, redirect=0 SHALL, in the same cycle:
- pulse fifo_push0=1 and inst_ok_1=1;
- set fifo_push1=inst_ok_2=1 only when tag[2]==0 and the request was cached;
- drive fifo_pc=tag;
- return to IDLE.
REQ-019 A redirect in WAIT before irsp_valid SHALL go to DRAIN; the outstanding response is consumed with no push and no inst_ok, then DRAIN -> IDLE.
REQ-020 A redirect coincident with irsp_valid in WAIT SHALL discard that response and go directly to IDLE.
REQ-021 A redirect in REQ before the handshake SHALL drop ireq_valid the next cycle and go to IDLE; a redirect in the handshake cycle itself SHALL go to DRAIN.
REQ-022 pc_en SHALL be 1 in every state except DRAIN and FAULT; a redirect is still accepted in those two states.
REQ-023 inst_ok_1/inst_ok_2 SHALL be 0 outside the REQ-018 cycle; at most one request is outstanding at any time.
REQ-024 fifo_full does not stall an accepted response: REQ-014 gating guarantees space for two entries.
REQ-025 ireq_addr and ireq_uncached SHALL remain stable while ireq_valid=1 and ireq_ready=0.

Reset
REQ-026 While rst=1 the block SHALL:
- hold state IDLE;
- drive every output 0 and clear the tag;
- discard any in-flight response.
REQ-027 Reset mid-transaction SHALL not emit any push; a response arriving in the first cycle after reset is ignored.

Structure
REQ-028 The FSM state enum and the fetch_exc_code constants SHALL live in the shared package sirius_pkg.
REQ-029 The block is a single module with no sub-modules: a registered FSM plus a combinational output decode.

Verification
REQ-030 Reset, pc_address=bfc00000 (cached), ready=1, response after 2 cycles -> fifo_push0=fifo_push1=1, fifo_pc=bfc00000, inst_ok_1=inst_ok_2=1 for one cycle.
REQ-031 pc_address=bfc00004 -> fifo_push0=1, fifo_push1=0, inst_ok_2=0.
REQ-032 Redirect one cycle after the handshake, response 3 cycles later -> no push; pc_en=0 during DRAIN; next request uses the new PC.
REQ-033 tlb_miss=1 in REQ -> ireq_valid stays 0, fetch_exc=1 with code 0 until redirect, then IDLE.
REQ-034 fifo_full=1 for 5 cycles -> no ireq_valid during those cycles; a request is issued the cycle after fifo_full falls.
REQ-035 rst asserted while in WAIT, response arrives next cycle -> no push and all outputs 0.

Source files
------------

// File: rtl/sirius_pkg.sv
// Shared fetch-side types: fetch FSM state encoding and fetch fault codes.
package sirius_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned EXC_CODEW = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    FAULT = 3'd4
  } fetch_state_e;

  localparam logic [EXC_CODEW-1:0] EXC_TLB_REFILL  = 2'd0;
  localparam logic [EXC_CODEW-1:0] EXC_TLB_INVALID = 2'd1;
  localparam logic [EXC_CODEW-1:0] EXC_ADDR_ERR    = 2'd2;

  // Illegal address outranks a refill, which outranks an invalid entry.
  function automatic logic [EXC_CODEW-1:0] tlb_exc_code(input logic illegal, input logic miss);
    if (illegal)   return EXC_ADDR_ERR;
    else if (miss) return EXC_TLB_REFILL;
    else           return EXC_TLB_INVALID;
  endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding memory request, FIFO push of the
// returned word pair, TLB fault reporting and redirect flush.
module fetch_ctrl
  import sirius_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [XLEN-1:0]      pc_address,
  input  logic [XLEN-1:0]      pc_address_psy,
  input  logic                 tlb_miss,
  input  logic                 tlb_illegal,
  input  logic                 tlb_invalid,
  input  logic                 tlb_uncached,
  input  logic                 redirect,
  input  logic                 fifo_full,
  output logic                 pc_en,
  output logic                 inst_ok_1,
  output logic                 inst_ok_2,
  output logic                 ireq_valid,
  input  logic                 ireq_ready,
  output logic [XLEN-1:0]      ireq_addr,
  output logic                 ireq_uncached,
  input  logic                 irsp_valid,
  input  logic [XLEN-1:0]      irsp_data0,
  input  logic [XLEN-1:0]      irsp_data1,
  output logic                 fifo_push0,
  output logic                 fifo_push1,
  output logic [XLEN-1:0]      fifo_pc,
  output logic [XLEN-1:0]      fifo_inst0,
  output logic [XLEN-1:0]      fifo_inst1,
  output logic                 fetch_exc,
  output logic [EXC_CODEW-1:0] fetch_exc_code
);

  fetch_state_e         state_q, state_d;
  logic [XLEN-1:0]      tag_q;
  logic                 tag_unc_q;
  logic [EXC_CODEW-1:0] exc_code_q;
  logic                 hold_q;
  logic [XLEN-1:0]      hold_addr_q;
  logic [XLEN-1:0]      hold_pc_q;
  logic                 hold_unc_q;

  logic                 tlb_fault;
  logic                 req_fire;
  logic [XLEN-1:0]      req_addr;
  logic [XLEN-1:0]      req_pc;
  logic                 req_unc;

  // A request stalled on ireq_ready replays its first-cycle snapshot so the
  // channel stays stable even if the PC-side inputs wander.
  assign tlb_fault = tlb_miss | tlb_invalid | tlb_illegal;
  assign req_addr  = hold_q ? hold_addr_q : pc_address_psy;
  assign req_pc    = hold_q ? hold_pc_q   : pc_address;
  assign req_unc   = hold_q ? hold_unc_q  : tlb_uncached;

  // Next-state and output decode; everything reads as zero while rst is high.
  always_comb begin
    state_d        = state_q;
    req_fire       = 1'b0;
    pc_en          = 1'b0;
    inst_ok_1      = 1'b0;
    inst_ok_2      = 1'b0;
    ireq_valid     = 1'b0;
    ireq_addr      = '0;
    ireq_uncached  = 1'b0;
    fifo_push0     = 1'b0;
    fifo_push1     = 1'b0;
    fifo_pc        = '0;
    fifo_inst0     = '0;
    fifo_inst1     = '0;
    fetch_exc      = 1'b0;
    fetch_exc_code = EXC_TLB_REFILL;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          pc_en = 1'b1;
          if (redirect)       state_d = IDLE;
          else if (tlb_fault) state_d = FAULT;
          else if (!fifo_full) state_d = REQ;
        end
        REQ: begin
          pc_en = 1'b1;
          if (!tlb_fault) begin
            ireq_valid    = 1'b1;
            ireq_addr     = req_addr;
            ireq_uncached = req_unc;
            req_fire      = ireq_ready;
          end
          if (req_fire)       state_d = redirect ? DRAIN : WAIT;
          else if (redirect)  state_d = IDLE;
          else if (tlb_fault) state_d = FAULT;
        end
        WAIT: begin
          pc_en = 1'b1;
          if (irsp_valid) begin
            state_d = IDLE;
            if (!redirect) begin
              fifo_push0 = 1'b1;
              inst_ok_1  = 1'b1;
              fifo_push1 = ~tag_q[2] & ~tag_unc_q;
              inst_ok_2  = ~tag_q[2] & ~tag_unc_q;
              fifo_pc    = tag_q;
              fifo_inst0 = irsp_data0;
              fifo_inst1 = irsp_data1;
            end
          end else if (redirect) begin
            state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (irsp_valid) state_d = IDLE;
        end
        FAULT: begin
          fetch_exc      = 1'b1;
          fetch_exc_code = exc_code_q;
          if (redirect) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tag_q       <= '0;
      tag_unc_q   <= 1'b0;
      exc_code_q  <= EXC_TLB_REFILL;
      hold_q      <= 1'b0;
      hold_addr_q <= '0;
      hold_pc_q   <= '0;
      hold_unc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (req_fire) begin
        tag_q     <= req_pc;
        tag_unc_q <= req_unc;
      end
      if (state_q != FAULT && state_d == FAULT)
        exc_code_q <= tlb_exc_code(tlb_illegal, tlb_miss);
      hold_q <= (state_q == REQ) && (state_d == REQ);
      if (state_q == REQ && !hold_q) begin
        hold_addr_q <= pc_address_psy;
        hold_pc_q   <= pc_address;
        hold_unc_q  <= tlb_uncached;
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: hand-computed expectations checked with immediate assertions.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_address, pc_address_psy;
  logic        tlb_miss, tlb_illegal, tlb_invalid, tlb_uncached;
  logic        redirect, fifo_full;
  logic        pc_en, inst_ok_1, inst_ok_2;
  logic        ireq_valid, ireq_ready, ireq_uncached;
  logic [31:0] ireq_addr;
  logic        irsp_valid;
  logic [31:0] irsp_data0, irsp_data1;
  logic        fifo_push0, fifo_push1;
  logic [31:0] fifo_pc, fifo_inst0, fifo_inst1;
  logic        fetch_exc;
  logic [1:0]  fetch_exc_code;

  int n_chk  = 0;
  int n_fail = 0;

  fetch_ctrl dut (
    .clk(clk), .rst(rst),
    .pc_address(pc_address), .pc_address_psy(pc_address_psy),
    .tlb_miss(tlb_miss), .tlb_illegal(tlb_illegal), .tlb_invalid(tlb_invalid),
    .tlb_uncached(tlb_uncached), .redirect(redirect), .fifo_full(fifo_full),
    .pc_en(pc_en), .inst_ok_1(inst_ok_1), .inst_ok_2(inst_ok_2),
    .ireq_valid(ireq_valid), .ireq_ready(ireq_ready), .ireq_addr(ireq_addr),
    .ireq_uncached(ireq_uncached), .irsp_valid(irsp_valid),
    .irsp_data0(irsp_data0), .irsp_data1(irsp_data1),
    .fifo_push0(fifo_push0), .fifo_push1(fifo_push1), .fifo_pc(fifo_pc),
    .fifo_inst0(fifo_inst0), .fifo_inst1(fifo_inst1),
    .fetch_exc(fetch_exc), .fetch_exc_code(fetch_exc_code)
  );

  always #5 clk = ~clk;

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic all_zero(input string tag);
    chk32({tag, "_ctl"}, {22'd0, pc_en, inst_ok_1, inst_ok_2, ireq_valid, ireq_uncached,
                          fifo_push0, fifo_push1, fetch_exc, fetch_exc_code}, 32'd0);
    chk32({tag, "_bus"}, ireq_addr | fifo_pc | fifo_inst0 | fifo_inst1, 32'd0);
  endtask

  initial begin
    rst = 1'b1; pc_address = 32'hbfc0_0000; pc_address_psy = 32'h1fc0_0000;
    tlb_miss = 1'b0; tlb_illegal = 1'b0; tlb_invalid = 1'b0; tlb_uncached = 1'b0;
    redirect = 1'b0; fifo_full = 1'b0; ireq_ready = 1'b1; irsp_valid = 1'b0;
    irsp_data0 = 32'h1111_1111; irsp_data1 = 32'h2222_2222;

    // Reset, then a cached fetch at bfc00000 with a two-cycle response.
    go(); #1; all_zero("rst_hold");
    rst = 1'b0; #1;
    chk1("idle_pc_en", pc_en, 1'b1); chk1("idle_noreq", ireq_valid, 1'b0);
    go(); #1;
    chk1("req_valid", ireq_valid, 1'b1); chk32("req_addr", ireq_addr, 32'h1fc0_0000);
    chk1("req_unc", ireq_uncached, 1'b0);
    go(); #1;
    chk1("wait_nopush", fifo_push0, 1'b0); chk1("wait_nook", inst_ok_1, 1'b0);
    go(); irsp_valid = 1'b1; #1;
    chk1("rsp_push0", fifo_push0, 1'b1); chk1("rsp_push1", fifo_push1, 1'b1);
    chk32("rsp_pc", fifo_pc, 32'hbfc0_0000); chk32("rsp_i0", fifo_inst0, 32'h1111_1111);
    chk32("rsp_i1", fifo_inst1, 32'h2222_2222);
    chk1("rsp_ok1", inst_ok_1, 1'b1); chk1("rsp_ok2", inst_ok_2, 1'b1);
    go(); irsp_valid = 1'b0; pc_address = 32'hbfc0_0004; pc_address_psy = 32'h1fc0_0004; #1;
    chk1("post_push0", fifo_push0, 1'b0); chk1("post_ok1", inst_ok_1, 1'b0);

    // Odd-word PC: only one instruction usable.
    go(); #1; chk32("odd_addr", ireq_addr, 32'h1fc0_0004);
    go(); irsp_valid = 1'b1; #1;
    chk1("odd_push0", fifo_push0, 1'b1); chk1("odd_push1", fifo_push1, 1'b0);
    chk1("odd_ok2", inst_ok_2, 1'b0); chk32("odd_pc", fifo_pc, 32'hbfc0_0004);

    // Uncached request stalled on ready: channel held stable, single push.
    go(); irsp_valid = 1'b0; ireq_ready = 1'b0; tlb_uncached = 1'b1;
    pc_address = 32'hbfc0_0008; pc_address_psy = 32'h1fc0_0008;
    go(); #1;
    chk1("stall_valid", ireq_valid, 1'b1); chk32("stall_addr0", ireq_addr, 32'h1fc0_0008);
    chk1("stall_unc0", ireq_uncached, 1'b1);
    go(); pc_address_psy = 32'hdead_beec; pc_address = 32'h1234_5670; tlb_uncached = 1'b0;
    ireq_ready = 1'b1; #1;
    chk32("stall_addr1", ireq_addr, 32'h1fc0_0008); chk1("stall_unc1", ireq_uncached, 1'b1);
    go(); irsp_valid = 1'b1; #1;
    chk1("unc_push0", fifo_push0, 1'b1); chk1("unc_push1", fifo_push1, 1'b0);
    chk32("unc_pc", fifo_pc, 32'hbfc0_0008);

    // Redirect one cycle after handshake, response three cycles later.
    go(); irsp_valid = 1'b0; pc_address = 32'hbfc0_0010; pc_address_psy = 32'h1fc0_0010;
    go(); #1; chk1("rd_req", ireq_valid, 1'b1);
    go(); redirect = 1'b1; #1;
    chk1("rd_wait_pcen", pc_en, 1'b1); chk1("rd_wait_nopush", fifo_push0, 1'b0);
    go(); redirect = 1'b0; pc_address = 32'h8000_1000; pc_address_psy = 32'h0000_1000; #1;
    chk1("drain_pcen0", pc_en, 1'b0); chk1("drain_novalid", ireq_valid, 1'b0);
    go(); #1; chk1("drain_pcen1", pc_en, 1'b0);
    go(); irsp_valid = 1'b1; #1;
    chk1("drain_nopush", fifo_push0, 1'b0); chk1("drain_nook", inst_ok_1, 1'b0);
    chk1("drain_pcen2", pc_en, 1'b0);
    go(); irsp_valid = 1'b0; #1;
    chk1("rd_idle_pcen", pc_en, 1'b1); chk1("rd_idle_nopush", fifo_push0, 1'b0);
    go(); #1; chk32("rd_new_addr", ireq_addr, 32'h0000_1000);
    go(); irsp_valid = 1'b1; irsp_data0 = 32'h3333_3333; irsp_data1 = 32'h4444_4444; #1;
    chk1("rd_new_push1", fifo_push1, 1'b1); chk32("rd_new_pc", fifo_pc, 32'h8000_1000);
    chk32("rd_new_i1", fifo_inst1, 32'h4444_4444);

    // TLB miss while in REQ: fault held until redirect.
    go(); irsp_valid = 1'b0; pc_address = 32'hbfc0_0020; pc_address_psy = 32'h1fc0_0020;
    go(); tlb_miss = 1'b1; #1; chk1("miss_novalid", ireq_valid, 1'b0);
    go(); tlb_miss = 1'b0; tlb_illegal = 1'b1; #1;
    chk1("fault_exc", fetch_exc, 1'b1); chk32("fault_code", 32'(fetch_exc_code), 32'd0);
    chk1("fault_pcen", pc_en, 1'b0); chk1("fault_novalid", ireq_valid, 1'b0);
    go(); redirect = 1'b1; #1;
    chk1("fault_exc_rd", fetch_exc, 1'b1); chk32("fault_code_rd", 32'(fetch_exc_code), 32'd0);

    // Illegal and miss together in IDLE: address error wins.
    go(); redirect = 1'b0; tlb_illegal = 1'b1; tlb_miss = 1'b1; #1;
    chk1("exit_noexc", fetch_exc, 1'b0); chk1("exit_pcen", pc_en, 1'b1);
    chk1("idle_fault_novalid", ireq_valid, 1'b0);
    go(); tlb_illegal = 1'b0; tlb_miss = 1'b0; redirect = 1'b1; #1;
    chk32("prio_code", 32'(fetch_exc_code), 32'd2);
    go(); redirect = 1'b0; tlb_invalid = 1'b1; #1; chk1("inv_idle", fetch_exc, 1'b0);
    go(); tlb_invalid = 1'b0; redirect = 1'b1; #1;
    chk32("inv_code", 32'(fetch_exc_code), 32'd1);

    // fifo_full held for five cycles blocks new requests.
    go(); redirect = 1'b0; fifo_full = 1'b1; #1; chk1("full_0", ireq_valid, 1'b0);
    for (int i = 1; i < 5; i++) begin
      go(); #1; chk1($sformatf("full_%0d", i), ireq_valid, 1'b0);
    end
    go(); fifo_full = 1'b0; #1; chk1("full_fall", ireq_valid, 1'b0);
    go(); #1;
    chk1("full_req", ireq_valid, 1'b1); chk32("full_addr", ireq_addr, 32'h1fc0_0020);

    // Reset in WAIT with a response arriving under and right after reset.
    go(); rst = 1'b1; #1; all_zero("rst_wait");
    go(); irsp_valid = 1'b1; #1; all_zero("rst_rsp");
    go(); rst = 1'b0; #1;
    chk1("post_rst_nopush", fifo_push0, 1'b0); chk1("post_rst_nook", inst_ok_1, 1'b0);

    // Redirect in REQ before handshake, then in the handshake cycle.
    go(); irsp_valid = 1'b0; ireq_ready = 1'b0; redirect = 1'b1; #1;
    chk1("rdreq_valid", ireq_valid, 1'b1);
    go(); redirect = 1'b0; #1;
    chk1("rdreq_drop", ireq_valid, 1'b0); chk1("rdreq_idle_pcen", pc_en, 1'b1);
    go(); ireq_ready = 1'b1; redirect = 1'b1; #1; chk1("rdhs_valid", ireq_valid, 1'b1);
    go(); redirect = 1'b0; #1; chk1("rdhs_drain", pc_en, 1'b0);
    go(); irsp_valid = 1'b1; #1; chk1("rdhs_nopush", fifo_push0, 1'b0);
    go(); irsp_valid = 1'b0; #1;
    chk1("rdhs_idle", pc_en, 1'b1); chk1("rdhs_idle_nv", ireq_valid, 1'b0);

    // Redirect coincident with the response: discarded, straight to IDLE.
    go(); #1; chk1("co_req", ireq_valid, 1'b1);
    go(); irsp_valid = 1'b1; redirect = 1'b1; #1;
    chk1("co_nopush", fifo_push0, 1'b0); chk1("co_nook", inst_ok_1, 1'b0);
    go(); irsp_valid = 1'b0; redirect = 1'b0; #1;
    chk1("co_idle_nv", ireq_valid, 1'b0); chk1("co_idle_pcen", pc_en, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
